tcb_lib_responder_memory: RTL

TCB_LIB_RESPONDER_MEMORY -- requirements
Module: tcb_lib_responder_memory

---
 rtl/tcb_pkg.sv | 33 +++
 rtl/tcb_if.sv | 19 +
 rtl/tcb_lib_rsp_delay.sv | 46 ++++
 rtl/tcb_lib_responder_memory.sv | 122 ++++++++++++
 4 files changed

// File: rtl/tcb_pkg.sv
// Shared TCB bus widths and the request/response payload types.
package tcb_pkg;

    localparam int unsigned TCB_ADR   = 32;
    localparam int unsigned TCB_DAT   = 32;
    localparam int unsigned TCB_BEN   = TCB_DAT / 8;
    localparam int unsigned TCB_SIZ_W = 2;

    typedef struct packed {
        logic inc;
        logic rpt;
        logic lck;
    } tcb_cmd_t;

    typedef struct packed {
        tcb_cmd_t               cmd;
        logic                   wen;
        logic [TCB_ADR-1:0]     adr;
        logic [TCB_SIZ_W-1:0]   siz;
        logic [TCB_BEN-1:0]     ben;
        logic [TCB_DAT-1:0]     wdt;
    } tcb_req_t;

    typedef struct packed {
        logic err;
    } tcb_sts_t;

    typedef struct packed {
        logic [TCB_DAT-1:0] rdt;
        tcb_sts_t           sts;
    } tcb_rsp_t;

endpackage

// File: rtl/tcb_if.sv
// TCB point-to-point link; HSK_DLY is the request-to-response latency in cycles.
interface tcb_if
    import tcb_pkg::*;
#(
    parameter int unsigned HSK_DLY = 1
)(
    input logic clk,
    input logic rst
);

    logic     vld;
    tcb_req_t req;
    logic     rdy;
    tcb_rsp_t rsp;

    modport man (input clk, input rst, output vld, output req, input rdy, input rsp);
    modport sub (input clk, input rst, input vld, input req, output rdy, output rsp);

endinterface

// File: rtl/tcb_lib_rsp_delay.sv
// Fixed-latency response delay line; DEPTH=0 is a straight combinational pass-through.
module tcb_lib_rsp_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_i,
    input  logic [DW-1:0] dat_i,
    output logic          vld_o,
    output logic [DW-1:0] dat_o
);

    if (DEPTH == 0) begin : g_comb
        assign vld_o = vld_i;
        assign dat_o = dat_i;
    end else begin : g_pipe
        logic          vld_q [DEPTH];
        logic [DW-1:0] dat_q [DEPTH];

        // Only the valid bits need clearing; stale data is never presented.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    vld_q[i] <= 1'b0;
                end
            end else begin
                vld_q[0] <= vld_i;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            dat_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
        end

        assign vld_o = vld_q[DEPTH-1];
        assign dat_o = dat_q[DEPTH-1];
    end

endmodule

// File: rtl/tcb_lib_responder_memory.sv
// Byte-enabled memory behind a TCB subordinate port, with optional post-transfer stall.
module tcb_lib_responder_memory
    import tcb_pkg::*;
#(
    parameter int unsigned MEM_SIZ = 1024,
    parameter int          STL     = 0
)(
    input  logic clk,
    input  logic rst,
    tcb_if.sub   sub
);

    localparam int unsigned DLY    = sub.HSK_DLY;
    localparam int unsigned BEN_W  = $clog2(TCB_BEN);
    localparam int unsigned MEM_AW = $clog2(MEM_SIZ);
    localparam int unsigned WORDS  = MEM_SIZ / TCB_BEN;
    localparam int unsigned WRD_W  = (MEM_AW > BEN_W) ? MEM_AW - BEN_W : 1;
    localparam int unsigned STL_N  = (STL > 0) ? unsigned'(STL) : 0;
    localparam int unsigned CNT_W  = (STL_N > 0) ? $clog2(STL_N + 1) : 1;
    localparam int unsigned RSP_W  = $bits(tcb_rsp_t);

    if (((MEM_SIZ & (MEM_SIZ - 1)) != 0) || (MEM_SIZ < TCB_BEN)) begin : g_chk_siz
        $error("MEM_SIZ must be a power of two and at least the bus byte count");
    end
    if (STL < 0) begin : g_chk_stl
        $error("STL must not be negative");
    end

    // Out of range, or not aligned to the transfer size.
    function automatic logic req_err(input logic [TCB_ADR-1:0]   adr,
                                     input logic [TCB_SIZ_W-1:0] siz);
        logic [TCB_ADR-1:0] msk;
        msk = (TCB_ADR'(1) << siz) - TCB_ADR'(1);
        return (adr >= TCB_ADR'(MEM_SIZ)) || ((adr & msk) != '0);
    endfunction

    logic [TCB_DAT-1:0] mem_q [WORDS];
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               rdy_q;
    logic               trn_c;
    logic               err_c;
    logic [WRD_W-1:0]   wrd_c;
    tcb_rsp_t           rsp_c;
    tcb_rsp_t           rsp_q;
    tcb_rsp_t           dly_rsp;
    logic               dly_vld;
    logic [RSP_W-1:0]   dly_dat;
    logic               cmd_unused;

    assign cmd_unused = ^sub.req.cmd;

    assign trn_c = sub.vld & rdy_q & rst;
    assign err_c = req_err(sub.req.adr, sub.req.siz);
    assign wrd_c = WRD_W'(sub.req.adr >> BEN_W);

    always_ff @(posedge clk) begin
        if (trn_c && sub.req.wen && !err_c) begin
            for (int i = 0; i < TCB_BEN; i++) begin
                if (sub.req.ben[i]) begin
                    mem_q[wrd_c][8*i +: 8] <= sub.req.wdt[8*i +: 8];
                end
            end
        end
    end

    // Reload on every transfer, then count down; rdy is high only at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (trn_c && (STL_N > 0)) begin
            cnt_d = CNT_W'(STL_N);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            rdy_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d == '0);
        end
    end

    always_comb begin
        rsp_c = '0;
        if (err_c) begin
            rsp_c.sts.err = 1'b1;
        end else if (!sub.req.wen) begin
            rsp_c.rdt = mem_q[wrd_c];
        end
    end

    tcb_lib_rsp_delay #(
        .DEPTH (DLY),
        .DW    (RSP_W)
    ) u_rsp_delay (
        .clk   (clk),
        .rst   (rst),
        .vld_i (trn_c),
        .dat_i (rsp_c),
        .vld_o (dly_vld),
        .dat_o (dly_dat)
    );

    assign dly_rsp = tcb_rsp_t'(dly_dat);

    // Keeps the last response visible between response slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_q <= '0;
        end else if (dly_vld) begin
            rsp_q <= dly_rsp;
        end
    end

    assign sub.rsp = dly_vld ? dly_rsp : rsp_q;
    assign sub.rdy = rdy_q;

endmodule
